// File: rtl/axil_pkg.sv
// Shared definitions for the AXI4-Lite register responders.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic { W_IDLE, W_RESP } wstate_e;
    typedef enum logic { R_IDLE, R_RESP } rstate_e;

    // Word-index width for a byte address decoded over addr_w bits.
    function automatic int idx_w(input int addr_w);
        return addr_w - 2;
    endfunction

endpackage

// File: rtl/axil_wstrb_merge.sv
// Byte-lane merge of a write into an existing 32-bit word.
module axil_wstrb_merge (
    input  logic [31:0] old_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  wstrb_i,
    output logic [31:0] merged_o
);

    for (genvar b = 0; b < 4; b++) begin : g_byte
        assign merged_o[8*b +: 8] = wstrb_i[b] ? wdata_i[8*b +: 8] : old_i[8*b +: 8];
    end

endmodule

// File: rtl/axil_reg_responder.sv
// AXI4-Lite responder: NREGS writable control registers plus a read-only
// status word at index NREGS; independent read and write channels.
module axil_reg_responder
    import axil_pkg::*;
#(
    parameter int          NREGS     = 8,
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] RESET_VAL = 32'h0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  awvalid,
    output logic                  awready,
    input  logic [31:0]           awaddr,
    input  logic [2:0]            awprot,
    input  logic                  wvalid,
    output logic                  wready,
    input  logic [31:0]           wdata,
    input  logic [3:0]            wstrb,
    output logic                  bvalid,
    input  logic                  bready,
    output logic [1:0]            bresp,
    input  logic                  arvalid,
    output logic                  arready,
    input  logic [31:0]           araddr,
    input  logic [2:0]            arprot,
    output logic                  rvalid,
    input  logic                  rready,
    output logic [31:0]           rdata,
    output logic [1:0]            rresp,
    output logic [32*NREGS-1:0]   regs_out,
    input  logic [31:0]           status_in
);

    localparam int              IDX_W    = idx_w(ADDR_W);
    localparam logic [IDX_W-1:0] STAT_IDX = IDX_W'(NREGS);

    wstate_e                    wstate_q, wstate_d;
    rstate_e                    rstate_q, rstate_d;
    logic                       live_q;
    logic                       aw_held_q, aw_held_d;
    logic                       w_held_q, w_held_d;
    logic [IDX_W-1:0]           awidx_q, awidx_d;
    logic [31:0]                wdata_q, wdata_d;
    logic [3:0]                 wstrb_q, wstrb_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic [NREGS-1:0][31:0]     regs_q, regs_d;

    logic                       aw_fire, w_fire, ar_fire, wr_go;
    logic [IDX_W-1:0]           cur_idx, ar_idx;
    logic [31:0]                cur_data, old_word, merged, rd_word;
    logic [3:0]                 cur_strb;
    logic                       unused_ok;

    // live_q keeps the readies low during reset and for the release edge.
    assign awready  = live_q && (wstate_q == W_IDLE) && !aw_held_q;
    assign wready   = live_q && (wstate_q == W_IDLE) && !w_held_q;
    assign arready  = live_q && (rstate_q == R_IDLE);
    assign bvalid   = (wstate_q == W_RESP);
    assign rvalid   = (rstate_q == R_RESP);
    assign bresp    = bresp_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign regs_out = regs_q;

    assign aw_fire  = awvalid && awready;
    assign w_fire   = wvalid && wready;
    assign ar_fire  = arvalid && arready;
    assign wr_go    = (aw_held_q || aw_fire) && (w_held_q || w_fire);

    // Held copies win; otherwise the commit uses the live bus values.
    assign cur_idx  = aw_held_q ? awidx_q : awaddr[ADDR_W-1:2];
    assign cur_data = w_held_q  ? wdata_q : wdata;
    assign cur_strb = w_held_q  ? wstrb_q : wstrb;
    assign ar_idx   = araddr[ADDR_W-1:2];

    assign unused_ok = ^{awaddr[31:ADDR_W], awaddr[1:0], araddr[31:ADDR_W],
                         araddr[1:0], awprot, arprot};

    always_comb begin
        old_word = '0;
        for (int k = 0; k < NREGS; k++)
            if (cur_idx == IDX_W'(k)) old_word = regs_q[k];
    end

    axil_wstrb_merge u_merge (
        .old_i    (old_word),
        .wdata_i  (cur_data),
        .wstrb_i  (cur_strb),
        .merged_o (merged)
    );

    always_comb begin
        rd_word = '0;
        if (ar_idx == STAT_IDX) rd_word = status_in;
        for (int k = 0; k < NREGS; k++)
            if (ar_idx == IDX_W'(k)) rd_word = regs_q[k];
    end

    always_comb begin
        wstate_d  = wstate_q;
        aw_held_d = aw_held_q;
        w_held_d  = w_held_q;
        awidx_d   = awidx_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bresp_d   = bresp_q;
        regs_d    = regs_q;
        case (wstate_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    awidx_d   = awaddr[ADDR_W-1:2];
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    wdata_d  = wdata;
                    wstrb_d  = wstrb;
                end
                if (wr_go) begin
                    wstate_d  = W_RESP;
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    if (cur_idx < STAT_IDX) begin
                        bresp_d = RESP_OKAY;
                        for (int k = 0; k < NREGS; k++)
                            if (cur_idx == IDX_W'(k)) regs_d[k] = merged;
                    end else if (cur_idx == STAT_IDX) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        bresp_d = RESP_DECERR;
                    end
                end
            end
            W_RESP: if (bready) wstate_d = W_IDLE;
        endcase
    end

    always_comb begin
        rstate_d = rstate_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        case (rstate_q)
            R_IDLE: begin
                if (ar_fire) begin
                    rstate_d = R_RESP;
                    rdata_d  = rd_word;
                    rresp_d  = (ar_idx <= STAT_IDX) ? RESP_OKAY : RESP_DECERR;
                end
            end
            R_RESP: if (rready) rstate_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            wstate_q  <= W_IDLE;
            rstate_q  <= R_IDLE;
            live_q    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            awidx_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            regs_q    <= {NREGS{RESET_VAL}};
        end else begin
            wstate_q  <= wstate_d;
            rstate_q  <= rstate_d;
            live_q    <= 1'b1;
            aw_held_q <= aw_held_d;
            w_held_q  <= w_held_d;
            awidx_q   <= awidx_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bresp_q   <= bresp_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            regs_q    <= regs_d;
        end
    end

endmodule

// File: tb/tb_axil_reg_responder.sv
// Randomized bench for axil_reg_responder against an array-based register model.
module tb_axil_reg_responder;

    localparam int NREGS = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         awvalid, awready, wvalid, wready, bvalid, bready;
    logic         arvalid, arready, rvalid, rready;
    logic [31:0]  awaddr, wdata, araddr, rdata, status_in;
    logic [2:0]   awprot, arprot;
    logic [3:0]   wstrb;
    logic [1:0]   bresp, rresp;
    logic [32*NREGS-1:0] regs_out;

    int errs   = 0;
    int checks = 0;
    logic [31:0] m [NREGS];

    axil_reg_responder #(.NREGS(NREGS), .ADDR_W(8), .RESET_VAL(32'h0)) dut (
        .clock(clock), .reset(reset),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .regs_out(regs_out), .status_in(status_in)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [255:0] pack();
        logic [255:0] v;
        for (int k = 0; k < NREGS; k++) v[32*k +: 32] = m[k];
        return v;
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NREGS; k++) m[k] = 32'h0;
    endtask

    // One write; AW and W start aw_dly/w_dly cycles in, bready held low for bp cycles.
    task automatic wr(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                      input int aw_dly, input int w_dly, input int bp);
        logic aw_done, w_done, aw_hs, w_hs;
        logic [1:0] eresp;
        logic [31:0] mask;
        int idx, cyc;
        idx   = int'(addr[7:2]);
        eresp = (idx < NREGS) ? 2'b00 : (idx == NREGS) ? 2'b10 : 2'b11;
        aw_done = 1'b0; w_done = 1'b0; cyc = 0; bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 30) begin
            if (!aw_done && cyc >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
            if (!w_done && cyc >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
            if (w_done && !aw_done) begin
                chk("wready_while_held", wready, 1'b0);
                chk("regs_before_aw", regs_out, pack());
            end
            if (aw_done && !w_done) chk("awready_while_held", awready, 1'b0);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; end
            cyc++;
        end
        chk("wr_handshakes_done", aw_done && w_done, 1'b1);
        if (!(aw_done && w_done)) begin
            awvalid = 1'b0; wvalid = 1'b0;
            return;
        end
        if (idx < NREGS) begin
            mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
            m[idx] = (m[idx] & ~mask) | (data & mask);
        end
        chk("bvalid_after_commit", bvalid, 1'b1);
        chk("bresp", bresp, eresp);
        chk("regs_after_commit", regs_out, pack());
        for (int i = 0; i < bp; i++) begin
            awvalid = 1'b1; awaddr = 32'h10; // stray address, must not be taken
            chk("awready_in_resp", awready, 1'b0);
            chk("wready_in_resp", wready, 1'b0);
            step();
            chk("bvalid_hold", bvalid, 1'b1);
            chk("bresp_hold", bresp, eresp);
        end
        awvalid = 1'b0;
        bready  = 1'b1;
        step();
        bready = 1'b0;
        chk("bvalid_drop", bvalid, 1'b0);
        chk("awready_back", awready, 1'b1);
        chk("regs_after_b", regs_out, pack());
    endtask

    // One read with status_in = stat at the handshake, rready low for bp cycles.
    task automatic rd(input logic [31:0] addr, input logic [31:0] stat, input int bp);
        logic [31:0] edata;
        logic [1:0]  eresp;
        int idx, cyc;
        idx = int'(addr[7:2]);
        status_in = stat;
        rready = 1'b0; arvalid = 1'b1; araddr = addr; cyc = 0;
        while (!arready && cyc < 10) begin step(); cyc++; end
        chk("arready", arready, 1'b1);
        if (!arready) begin arvalid = 1'b0; return; end
        edata = (idx < NREGS) ? m[idx] : (idx == NREGS) ? stat : 32'h0;
        eresp = (idx <= NREGS) ? 2'b00 : 2'b11;
        step();
        arvalid = 1'b0;
        chk("rvalid", rvalid, 1'b1);
        chk("rdata", rdata, edata);
        chk("rresp", rresp, eresp);
        for (int i = 0; i < bp; i++) begin
            status_in = $urandom;
            chk("arready_in_resp", arready, 1'b0);
            step();
            chk("rvalid_hold", rvalid, 1'b1);
            chk("rdata_hold", rdata, edata);
            chk("rresp_hold", rresp, eresp);
        end
        rready = 1'b1;
        step();
        rready = 1'b0;
        chk("rvalid_drop", rvalid, 1'b0);
        chk("arready_back", arready, 1'b1);
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] a;
        a = $urandom;
        a[7:2] = 6'($urandom_range(0, 10));
        return a;
    endfunction

    initial begin
        logic [31:0] old;
        reset = 1'b0;
        awvalid = 0; wvalid = 0; bready = 0; arvalid = 0; rready = 0;
        awaddr = 0; wdata = 0; wstrb = 0; araddr = 0; awprot = 0; arprot = 0;
        status_in = 0;
        model_reset();
        repeat (3) step();
        chk("rst_awready", awready, 1'b0);
        chk("rst_wready", wready, 1'b0);
        chk("rst_arready", arready, 1'b0);
        chk("rst_bvalid", bvalid, 1'b0);
        chk("rst_rvalid", rvalid, 1'b0);
        chk("rst_bresp", bresp, 2'b00);
        chk("rst_rresp", rresp, 2'b00);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_regs", regs_out, pack());
        reset = 1'b1;
        step();
        chk("rel_awready", awready, 1'b1);
        chk("rel_wready", wready, 1'b1);
        chk("rel_arready", arready, 1'b1);

        // Directed cases
        wr(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0);
        chk("reg1_deadbeef", regs_out[63:32], 32'hDEADBEEF);
        wr(32'h08, 32'h000000AA, 4'b0001, 3, 0, 0);
        wr(32'h08, 32'h11223344, 4'b1100, 0, 0, 0);
        chk("reg2_merge", regs_out[95:64], 32'h112200AA);
        rd(32'h20, 32'h0000CAFE, 0);
        rd(32'h24, 32'h12345678, 0);
        wr(32'h20, 32'hFFFFFFFF, 4'hF, 0, 0, 0);
        wr(32'h04, 32'h0BADF00D, 4'h0, 1, 0, 0);
        wr(32'hFFFFFF30, 32'h12121212, 4'hF, 0, 2, 1);

        // Randomized traffic
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 1) == 0)
                wr(rand_addr(), $urandom, 4'($urandom), $urandom_range(0, 3),
                   $urandom_range(0, 3), $urandom_range(0, 2));
            else
                rd(rand_addr(), $urandom, $urandom_range(0, 2));
        end

        // Back-pressure on both channels at once
        fork
            wr(32'h14, 32'hA5A5A5A5, 4'hF, 0, 0, 5);
            rd(32'h04, 32'h0, 5);
        join

        // Reset while both responses are pending
        bready = 0; rready = 0;
        awvalid = 1; awaddr = 32'h18; wvalid = 1; wdata = 32'h77; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h04;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        chk("pre_rst_bvalid", bvalid, 1'b1);
        chk("pre_rst_rvalid", rvalid, 1'b1);
        reset = 1'b0;
        step();
        model_reset();
        chk("mid_rst_bvalid", bvalid, 1'b0);
        chk("mid_rst_rvalid", rvalid, 1'b0);
        chk("mid_rst_regs", regs_out, pack());
        chk("mid_rst_awready", awready, 1'b0);
        reset = 1'b1;
        step();
        chk("post_rst_awready", awready, 1'b1);
        chk("post_rst_arready", arready, 1'b1);
        wr(32'h1C, 32'hCAFEF00D, 4'hF, 0, 1, 0);

        // Same-cycle read and write commit to one register
        old = m[3];
        bready = 1; rready = 0;
        awvalid = 1; awaddr = 32'h0C; wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
        arvalid = 1; araddr = 32'h0C;
        step();
        awvalid = 0; wvalid = 0; arvalid = 0;
        m[3] = 32'h55;
        chk("same_rvalid", rvalid, 1'b1);
        chk("same_rdata_old", rdata, old);
        chk("same_bvalid", bvalid, 1'b1);
        chk("same_regs", regs_out, pack());
        rready = 1;
        step();
        rready = 0; bready = 0;
        rd(32'h0C, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
